// File: rtl/buzzer_pkg.sv
// Shared types and default timing for the buzzer arbiter.
// Holds the FSM encoding, index width and default tone/burst/gap lengths.
package buzzer_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        GRANT = 2'd1,
        PLAY  = 2'd2,
        GAP   = 2'd3
    } state_e;

    localparam int IDX_W         = 4;
    localparam int DEF_N         = 10;
    localparam int DEF_W         = 4;
    localparam int DEF_TONE_DIV  = 50000;
    localparam int DEF_BURST_LEN = 20000000;
    localparam int DEF_GAP_LEN   = 5000000;

endpackage

// File: rtl/buzzer_arbiter_rr_pick.sv
// Combinational round-robin picker for the buzzer arbiter.
// Searches upward from last+1, wrapping N-1 -> 0.
module rr_pick
    import buzzer_pkg::*;
#(
    parameter int N = DEF_N
) (
    input  logic [N-1:0]     req,
    input  logic [IDX_W-1:0] last,
    output logic [IDX_W-1:0] idx,
    output logic             found
);

    int           j;
    logic [N-1:0] sel;

    // First requester after last, in circular order
    always_comb begin
        idx   = '0;
        found = 1'b0;
        j     = 0;
        sel   = '0;
        for (int k = 1; k <= N; k++) begin
            j   = (int'(last) + k) % N;
            sel = N'(1) << j;
            if (!found && (|(req & sel))) begin
                found = 1'b1;
                idx   = IDX_W'(j);
            end
        end
    end

endmodule

// File: rtl/buzzer_arbiter.sv
// Buzzer arbiter: queues per-object wrap alarms, plays them round-robin.
// Optional BUZZER_MISS_CNT_EN adds a saturating coalesced-alarm counter.
module buzzer_arbiter
    import buzzer_pkg::*;
#(
    parameter int N         = DEF_N,
    parameter int W         = DEF_W,
    parameter int TONE_DIV  = DEF_TONE_DIV,
    parameter int BURST_LEN = DEF_BURST_LEN,
    parameter int GAP_LEN   = DEF_GAP_LEN
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [N*W-1:0]   status,
    input  logic             enable,
    input  logic             clear,
    output logic             buzzer_pin,
    output logic             busy,
    output logic [IDX_W-1:0] active_idx,
    output logic [N-1:0]     pending
`ifdef BUZZER_MISS_CNT_EN
    ,
    output logic [7:0]       miss_cnt
`endif
);

    localparam int TONE_CW  = $clog2(TONE_DIV + 1);
    localparam int BURST_CW = $clog2(BURST_LEN + 1);
    localparam int GAP_CW   = $clog2(GAP_LEN + 1);

    state_e              state_q, state_d;
    logic [N-1:0]        zero_q, zero_d;
    logic [N-1:0]        pending_q, pending_d;
    logic [IDX_W-1:0]    idx_q, idx_d;
    logic [IDX_W-1:0]    last_q, last_d;
    logic                buzz_q, buzz_d;
    logic [TONE_CW-1:0]  tone_q, tone_d;
    logic [BURST_CW-1:0] burst_q, burst_d;
    logic [GAP_CW-1:0]   gap_q, gap_d;

    logic [N-1:0]        ev;
    logic [N-1:0]        grant_mask;
    logic [N-1:0]        abort_mask;
    logic                grant;
    logic                abort;
    logic [IDX_W-1:0]    pick_idx;
    logic                pick_found;

    rr_pick #(.N(N)) u_pick (
        .req   (pending_q),
        .last  (last_q),
        .idx   (pick_idx),
        .found (pick_found)
    );

    // Zero detect per slice; a fresh zero is an alarm event
    always_comb begin
        zero_d = '0;
        for (int i = 0; i < N; i++) begin
            zero_d[i] = (status[i*W +: W] == '0);
        end
        ev = zero_d & ~zero_q;
    end

    // Next state, grant/abort decisions and tone generation
    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        last_d  = last_q;
        buzz_d  = 1'b0;
        tone_d  = '0;
        burst_d = '0;
        gap_d   = '0;
        grant   = 1'b0;
        abort   = 1'b0;
        if (clear) begin
            state_d = IDLE;
        end else if (!enable) begin
            state_d = IDLE;
            abort   = (state_q == GRANT) || (state_q == PLAY);
        end else begin
            unique case (state_q)
                IDLE: begin
                    grant = pick_found;
                end
                GRANT: begin
                    state_d = PLAY;
                end
                PLAY: begin
                    if (burst_q == BURST_CW'(BURST_LEN - 1)) begin
                        state_d = GAP;
                    end else begin
                        burst_d = burst_q + 1'b1;
                        if (tone_q == TONE_CW'(TONE_DIV - 1)) begin
                            tone_d = '0;
                            buzz_d = ~buzz_q;
                        end else begin
                            tone_d = tone_q + 1'b1;
                            buzz_d = buzz_q;
                        end
                    end
                end
                GAP: begin
                    if (gap_q == GAP_CW'(GAP_LEN - 1)) begin
                        if (pick_found) begin
                            grant = 1'b1;
                        end else begin
                            state_d = IDLE;
                        end
                    end else begin
                        gap_d = gap_q + 1'b1;
                    end
                end
                default: begin
                    state_d = IDLE;
                end
            endcase
            if (grant) begin
                state_d = GRANT;
                idx_d   = pick_idx;
                last_d  = pick_idx;
            end
        end
    end

    // Pending queue: new events win over the grant that clears them
    always_comb begin
        grant_mask = grant ? (N'(1) << pick_idx) : '0;
        abort_mask = abort ? (N'(1) << idx_q) : '0;
        if (clear) begin
            pending_d = '0;
        end else begin
            pending_d = (pending_q & ~grant_mask) | abort_mask | ev;
        end
    end

    // State and datapath registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            zero_q    <= '1;
            pending_q <= '0;
            idx_q     <= '0;
            last_q    <= IDX_W'(N - 1);
            buzz_q    <= 1'b0;
            tone_q    <= '0;
            burst_q   <= '0;
            gap_q     <= '0;
        end else begin
            state_q   <= state_d;
            zero_q    <= zero_d;
            pending_q <= pending_d;
            idx_q     <= idx_d;
            last_q    <= last_d;
            buzz_q    <= buzz_d;
            tone_q    <= tone_d;
            burst_q   <= burst_d;
            gap_q     <= gap_d;
        end
    end

    assign buzzer_pin = buzz_q;
    assign busy       = (state_q != IDLE);
    assign active_idx = idx_q;
    assign pending    = pending_q;

`ifdef BUZZER_MISS_CNT_EN
    logic [7:0] miss_q, miss_d;

    // Count cycles where an alarm folds into an already queued one
    always_comb begin
        miss_d = miss_q;
        if (clear) begin
            miss_d = '0;
        end else if ((|(ev & pending_q)) && (miss_q != 8'hFF)) begin
            miss_d = miss_q + 8'd1;
        end
    end

    // Miss counter register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            miss_q <= '0;
        end else begin
            miss_q <= miss_d;
        end
    end

    assign miss_cnt = miss_q;
`endif

endmodule

// File: tb/tb_buzzer_arbiter.sv
// Self-checking bench for buzzer_arbiter with short timing.
// Directed scenarios plus random traffic against a behavioural model.
module tb_buzzer_arbiter;
    import buzzer_pkg::*;

    localparam int N  = 10;
    localparam int W  = 4;
    localparam int TD = 2;
    localparam int BL = 8;
    localparam int GL = 4;

    localparam int P_IDLE  = 0;
    localparam int P_GRANT = 1;
    localparam int P_PLAY  = 2;
    localparam int P_GAP   = 3;

    logic           clk = 1'b0;
    logic           rst_n = 1'b0;
    logic [N*W-1:0] status = '0;
    logic           enable = 1'b0;
    logic           clear = 1'b0;
    logic           buzzer_pin;
    logic           busy;
    logic [3:0]     active_idx;
    logic [N-1:0]   pending;
`ifdef BUZZER_MISS_CNT_EN
    logic [7:0]     miss_cnt;
`endif

    int n_checks = 0;
    int n_pass   = 0;

    always #5 clk = ~clk;

    buzzer_arbiter #(
        .N(N), .W(W), .TONE_DIV(TD), .BURST_LEN(BL), .GAP_LEN(GL)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .status     (status),
        .enable     (enable),
        .clear      (clear),
        .buzzer_pin (buzzer_pin),
        .busy       (busy),
        .active_idx (active_idx),
        .pending    (pending)
`ifdef BUZZER_MISS_CNT_EN
        ,
        .miss_cnt   (miss_cnt)
`endif
    );

    // Behavioural model: phase plus elapsed cycles, tone from arithmetic
    bit [N-1:0] m_zero;
    bit [N-1:0] m_pend;
    bit [N-1:0] m_ev;
    bit [N-1:0] m_nz;
    int         m_phase;
    int         m_t;
    int         m_idx;
    int         m_last;
    int         m_miss;
    int         m_pick;

    function automatic int rr(bit [N-1:0] req, int last);
        for (int k = 1; k <= N; k++) begin
            if (req[(last + k) % N]) return (last + k) % N;
        end
        return -1;
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_zero  = '1;
            m_pend  = '0;
            m_phase = P_IDLE;
            m_t     = 0;
            m_idx   = 0;
            m_last  = N - 1;
            m_miss  = 0;
        end else begin
            for (int i = 0; i < N; i++) begin
                m_nz[i] = (status[i*W +: W] == 0);
            end
            m_ev   = m_nz & ~m_zero;
            m_zero = m_nz;
            if ((m_ev & m_pend) != 0 && m_miss < 255) m_miss++;
            m_pick = -1;
            if (clear) begin
                m_pend  = '0;
                m_phase = P_IDLE;
                m_t     = 0;
                m_miss  = 0;
            end else if (!enable) begin
                if (m_phase == P_GRANT || m_phase == P_PLAY) begin
                    m_pend[m_idx] = 1'b1;
                end
                m_pend  = m_pend | m_ev;
                m_phase = P_IDLE;
                m_t     = 0;
            end else begin
                case (m_phase)
                    P_IDLE: begin
                        if (m_pend != 0) m_pick = rr(m_pend, m_last);
                    end
                    P_GRANT: begin
                        m_phase = P_PLAY;
                        m_t     = 0;
                    end
                    P_PLAY: begin
                        m_t++;
                        if (m_t == BL) begin
                            m_phase = P_GAP;
                            m_t     = 0;
                        end
                    end
                    default: begin
                        m_t++;
                        if (m_t == GL) begin
                            m_t = 0;
                            if (m_pend != 0) m_pick = rr(m_pend, m_last);
                            else m_phase = P_IDLE;
                        end
                    end
                endcase
                if (m_pick >= 0) begin
                    m_phase        = P_GRANT;
                    m_t            = 0;
                    m_idx          = m_pick;
                    m_last         = m_pick;
                    m_pend[m_pick] = 1'b0;
                end
                m_pend = m_pend | m_ev;
            end
        end
    end

    function automatic logic [15:0] exp_vec();
        logic b;
        b = (m_phase == P_PLAY) && (((m_t / TD) % 2) == 1);
        return {b, (m_phase != P_IDLE), 4'(m_idx), m_pend};
    endfunction

    function automatic logic [15:0] dut_vec();
        return {buzzer_pin, busy, active_idx, pending};
    endfunction

    task automatic test_reset();
        rst_n  = 1'b0;
        status = '0;
        enable = 1'b1;
        clear  = 1'b0;
        @(negedge clk);
        @(negedge clk);
        n_checks++;
        if (dut_vec() !== 16'h0000)
            $display("FAIL reset_outputs got %h exp 0000", dut_vec());
        else n_pass++;
        rst_n = 1'b1;
        repeat (3) begin
            @(negedge clk);
            n_checks++;
            if (dut_vec() !== exp_vec())
                $display("FAIL reset_model got %h exp %h", dut_vec(), exp_vec());
            else n_pass++;
        end
        status = {N{4'h1}};
        repeat (4) begin
            @(negedge clk);
            n_checks++;
            if (dut_vec() !== exp_vec())
                $display("FAIL reset_model got %h exp %h", dut_vec(), exp_vec());
            else n_pass++;
        end
        n_checks++;
        if ({buzzer_pin, pending} !== 11'h000)
            $display("FAIL no_powerup_alarm got %h exp 000", {buzzer_pin, pending});
        else n_pass++;
    endtask

    task automatic test_single();
        logic [1:0] e;
        status[3*W +: W] = 4'd9;
        @(negedge clk);
        status[3*W +: W] = 4'd0;
        @(negedge clk);
        n_checks++;
        if (pending !== 10'h008)
            $display("FAIL single_pending got %h exp 008", pending);
        else n_pass++;
        @(negedge clk);
        n_checks++;
        if ({busy, active_idx, pending} !== {1'b1, 4'd3, 10'h000})
            $display("FAIL single_grant got %b/%0d/%h exp 1/3/000",
                     busy, active_idx, pending);
        else n_pass++;
        for (int c = 0; c < BL + GL; c++) begin
            @(negedge clk);
            e = {(c < BL) && (((c / TD) % 2) == 1), 1'b1};
            n_checks++;
            if ({buzzer_pin, busy} !== e)
                $display("FAIL single_tone cyc %0d got %b exp %b", c,
                         {buzzer_pin, busy}, e);
            else n_pass++;
            n_checks++;
            if (dut_vec() !== exp_vec())
                $display("FAIL single_model got %h exp %h", dut_vec(), exp_vec());
            else n_pass++;
        end
        @(negedge clk);
        n_checks++;
        if (busy !== 1'b0)
            $display("FAIL single_idle got %b exp 0", busy);
        else n_pass++;
    endtask

    task automatic test_multi();
        int         order[$];
        int         exp_o[4];
        logic [3:0] pidx;
        logic       pbusy;
        int         step;
        exp_o = '{0, 5, 9, 0};
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        status[0*W +: W] = 4'd0;
        status[5*W +: W] = 4'd0;
        status[9*W +: W] = 4'd0;
        pbusy = 1'b0;
        pidx  = 4'd0;
        step  = 0;
        for (int c = 0; c < 70; c++) begin
            @(negedge clk);
            n_checks++;
            if (dut_vec() !== exp_vec())
                $display("FAIL multi_model got %h exp %h", dut_vec(), exp_vec());
            else n_pass++;
            if (busy && (!pbusy || active_idx != pidx)) order.push_back(int'(active_idx));
            pbusy = busy;
            pidx  = active_idx;
            if (step == 0 && order.size() == 3) begin
                status[0*W +: W] = 4'd1;
                step = 1;
            end else if (step == 1) begin
                status[0*W +: W] = 4'd0;
                step = 2;
            end
        end
        for (int i = 0; i < 4; i++) begin
            n_checks++;
            if (i >= order.size())
                $display("FAIL multi_order[%0d] got none exp %0d", i, exp_o[i]);
            else if (order[i] != exp_o[i])
                $display("FAIL multi_order[%0d] got %0d exp %0d", i, order[i], exp_o[i]);
            else n_pass++;
        end
    endtask

    task automatic test_requeue();
        int   rises;
        logic pb;
        rises = 0;
        pb    = 1'b0;
        status[5*W +: W] = 4'd1;
        @(negedge clk);
        status[5*W +: W] = 4'd0;
        for (int c = 0; c < 45; c++) begin
            @(negedge clk);
            n_checks++;
            if (dut_vec() !== exp_vec())
                $display("FAIL requeue_model got %h exp %h", dut_vec(), exp_vec());
            else n_pass++;
            if (buzzer_pin && !pb) rises++;
            pb = buzzer_pin;
            if (c == 3) status[5*W +: W] = 4'd1;
            if (c == 4) status[5*W +: W] = 4'd0;
            if (c == 5) begin
                n_checks++;
                if (pending[5] !== 1'b1)
                    $display("FAIL requeue_pending got %b exp 1", pending[5]);
                else n_pass++;
            end
        end
        n_checks++;
        if (rises != 4)
            $display("FAIL requeue_bursts got %0d rises exp 4", rises);
        else n_pass++;
    endtask

    task automatic test_abort();
        status[2*W +: W] = 4'd0;
        for (int c = 0; c < 16; c++) begin
            @(negedge clk);
            n_checks++;
            if (dut_vec() !== exp_vec())
                $display("FAIL abort_model got %h exp %h", dut_vec(), exp_vec());
            else n_pass++;
            case (c)
                4: enable = 1'b0;
                5: begin
                    n_checks++;
                    if ({buzzer_pin, busy, pending} !== {2'b00, 10'h004})
                        $display("FAIL abort_stop got %b/%b/%h exp 0/0/004",
                                 buzzer_pin, busy, pending);
                    else n_pass++;
                    enable = 1'b1;
                end
                6: begin
                    n_checks++;
                    if ({busy, active_idx} !== {1'b1, 4'd2})
                        $display("FAIL abort_replay got %b/%0d exp 1/2",
                                 busy, active_idx);
                    else n_pass++;
                    status[7*W +: W] = 4'd0;
                end
                8: clear = 1'b1;
                9: begin
                    clear = 1'b0;
                    n_checks++;
                    if ({buzzer_pin, busy, pending} !== 12'h000)
                        $display("FAIL abort_clear got %b/%b/%h exp 0/0/000",
                                 buzzer_pin, busy, pending);
                    else n_pass++;
                end
                default: ;
            endcase
        end
    endtask

    task automatic test_async_reset();
        status[4*W +: W] = 4'd0;
        repeat (5) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        n_checks++;
        if (dut_vec() !== 16'h0000)
            $display("FAIL async_reset got %h exp 0000", dut_vec());
        else n_pass++;
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        n_checks++;
        if (dut_vec() !== exp_vec())
            $display("FAIL async_model got %h exp %h", dut_vec(), exp_vec());
        else n_pass++;
    endtask

    task automatic test_random();
        for (int c = 0; c < 800; c++) begin
            @(negedge clk);
            n_checks++;
            if (dut_vec() !== exp_vec())
                $display("FAIL random_model cyc %0d got %h exp %h", c,
                         dut_vec(), exp_vec());
            else n_pass++;
`ifdef BUZZER_MISS_CNT_EN
            n_checks++;
            if (miss_cnt !== 8'(m_miss))
                $display("FAIL random_miss got %0d exp %0d", miss_cnt, m_miss);
            else n_pass++;
`endif
            for (int i = 0; i < N; i++) begin
                if ($urandom_range(0, 7) == 0) begin
                    if ($urandom_range(0, 2) == 0) status[i*W +: W] = 4'd0;
                    else status[i*W +: W] = 4'($urandom_range(1, 15));
                end
            end
            enable = ($urandom_range(0, 19) != 0);
            clear  = ($urandom_range(0, 59) == 0);
        end
        @(negedge clk);
        enable = 1'b1;
        clear  = 1'b0;
    endtask

`ifdef BUZZER_MISS_CNT_EN
    task automatic test_miss();
        clear  = 1'b1;
        enable = 1'b0;
        status[1*W +: W] = 4'd1;
        @(negedge clk);
        clear = 1'b0;
        status[1*W +: W] = 4'd0;
        @(negedge clk);
        n_checks++;
        if ({pending[1], miss_cnt} !== {1'b1, 8'd0})
            $display("FAIL miss_first got %b/%0d exp 1/0", pending[1], miss_cnt);
        else n_pass++;
        repeat (3) begin
            status[1*W +: W] = 4'd1;
            @(negedge clk);
            status[1*W +: W] = 4'd0;
            @(negedge clk);
        end
        n_checks++;
        if (miss_cnt !== 8'd3)
            $display("FAIL miss_three got %0d exp 3", miss_cnt);
        else n_pass++;
        repeat (300) begin
            status[1*W +: W] = 4'd1;
            @(negedge clk);
            status[1*W +: W] = 4'd0;
            @(negedge clk);
        end
        n_checks++;
        if (miss_cnt !== 8'd255)
            $display("FAIL miss_sat got %0d exp 255", miss_cnt);
        else n_pass++;
        clear = 1'b1;
        @(negedge clk);
        clear = 1'b0;
        n_checks++;
        if (miss_cnt !== 8'd0)
            $display("FAIL miss_clear got %0d exp 0", miss_cnt);
        else n_pass++;
        enable = 1'b1;
    endtask
`endif

    initial begin
        test_reset();
        test_single();
        test_multi();
        test_requeue();
        test_abort();
        test_async_reset();
        test_random();
`ifdef BUZZER_MISS_CNT_EN
        test_miss();
`endif
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
